// File: rtl/hdu_scoreboard.sv
// Decode-stage hazard unit: per-register countdown scoreboard plus flags-pop and PC-pop tracking.
// Optional stall/fetch-hold performance counters are built when HDU_STALL_PERF_EN is defined.
module hdu_scoreboard #(
  parameter int REG_ADDR_W = 3,
  parameter int LOAD_LAT   = 1,
  parameter int FLAGS_LAT  = 1,
  parameter int PC_LAT     = 3,
  parameter int CNT_W      = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       dec_valid,
  input  logic                       flush,
  input  logic [REG_ADDR_W-1:0]      dec_rs,
  input  logic [REG_ADDR_W-1:0]      dec_rd,
  input  logic                       dec_uses_rs,
  input  logic                       dec_uses_rd,
  input  logic                       dec_mem_to_reg,
  input  logic                       dec_flags_read,
  input  logic                       dec_pop_flags,
  input  logic                       dec_pop_pc,
  output logic                       stall,
  output logic                       mux_selector,
  output logic                       fetch_hold,
  output logic [2**REG_ADDR_W-1:0]   pending_mask
`ifdef HDU_STALL_PERF_EN
  ,
  output logic [CNT_W-1:0]           stall_cycles,
  output logic [CNT_W-1:0]           fetch_hold_cycles
`endif
);

  localparam int NUM_REGS = 2**REG_ADDR_W;
  localparam int LW = $clog2(LOAD_LAT + 1);
  localparam int FW = $clog2(FLAGS_LAT + 1);
  localparam int PW = $clog2(PC_LAT + 1);
  localparam logic [LW-1:0] LOAD_SET  = LW'(LOAD_LAT);
  localparam logic [FW-1:0] FLAGS_SET = FW'(FLAGS_LAT);
  localparam logic [PW-1:0] PC_SET    = PW'(PC_LAT);
  localparam logic [LW-1:0] LOAD_ONE  = LW'(1);
  localparam logic [FW-1:0] FLAGS_ONE = FW'(1);
  localparam logic [PW-1:0] PC_ONE    = PW'(1);

  logic [LW-1:0]       r_reg_cnt [NUM_REGS];
  logic [FW-1:0]       r_flags_cnt;
  logic [PW-1:0]       r_pc_cnt;
  logic                w_hit_rs;
  logic                w_hit_rd;
  logic                w_hit_f;
  logic                w_stall;
  logic                w_issue;
  logic                w_fetch_hold;
  logic [NUM_REGS-1:0] w_pending;

  // Hazards compare against pre-issue state, so an instruction never waits on its own result.
  assign w_hit_rs     = dec_uses_rs    & (r_reg_cnt[dec_rs] != {LW{1'b0}});
  assign w_hit_rd     = dec_uses_rd    & (r_reg_cnt[dec_rd] != {LW{1'b0}});
  assign w_hit_f      = dec_flags_read & (r_flags_cnt != {FW{1'b0}});
  assign w_stall      = dec_valid & ~flush & (w_hit_rs | w_hit_rd | w_hit_f);
  assign w_issue      = reset & dec_valid & ~flush & ~w_stall;
  assign w_fetch_hold = (r_pc_cnt != {PW{1'b0}}) | (w_issue & dec_pop_pc);

  assign stall        = w_stall;
  assign mux_selector = w_stall;
  assign fetch_hold   = w_fetch_hold;
  assign pending_mask = w_pending;

  // Flatten the register countdowns into a busy mask.
  always_comb begin
    w_pending = {NUM_REGS{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      w_pending[i] = (r_reg_cnt[i] != {LW{1'b0}});
    end
  end

  // Per-register countdowns; a new memory-sourced write reloads the entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_reg_cnt[i] <= {LW{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_issue && dec_mem_to_reg && (dec_rd == REG_ADDR_W'(i))) begin
          r_reg_cnt[i] <= LOAD_SET;
        end else if (r_reg_cnt[i] != {LW{1'b0}}) begin
          r_reg_cnt[i] <= r_reg_cnt[i] - LOAD_ONE;
        end
      end
    end
  end

  // Flags-pop and PC-pop countdowns.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags_cnt <= {FW{1'b0}};
      r_pc_cnt    <= {PW{1'b0}};
    end else begin
      if (w_issue && dec_pop_flags) begin
        r_flags_cnt <= FLAGS_SET;
      end else if (r_flags_cnt != {FW{1'b0}}) begin
        r_flags_cnt <= r_flags_cnt - FLAGS_ONE;
      end
      if (w_issue && dec_pop_pc) begin
        r_pc_cnt <= PC_SET;
      end else if (r_pc_cnt != {PW{1'b0}}) begin
        r_pc_cnt <= r_pc_cnt - PC_ONE;
      end
    end
  end

`ifdef HDU_STALL_PERF_EN
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_fetch_hold_cycles;

  // Free-running event counters, wrapping at their width.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cycles      <= {CNT_W{1'b0}};
      r_fetch_hold_cycles <= {CNT_W{1'b0}};
    end else begin
      if (w_stall) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
      if (w_fetch_hold) begin
        r_fetch_hold_cycles <= r_fetch_hold_cycles + CNT_W'(1);
      end
    end
  end

  assign stall_cycles      = r_stall_cycles;
  assign fetch_hold_cycles = r_fetch_hold_cycles;
`else
  logic [CNT_W-1:0] w_unused_perf;
  assign w_unused_perf = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hdu_scoreboard.sv
// Directed bench for hdu_scoreboard: three instances (default, LOAD_LAT=3, FLAGS_LAT=2) share decode inputs.
// Each instance has its own dec_valid; perf-counter checks apply when HDU_STALL_PERF_EN is defined.
module tb_hdu_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       v_def, v_ll3, v_fl2;
  logic       flush, urs, urd, m2r, fr, pf, ppc;
  logic [2:0] rs, rd;

  logic       def_stall, def_mux, def_fh;
  logic [7:0] def_pm;
  logic       ll3_stall, ll3_mux, ll3_fh;
  logic [7:0] ll3_pm;
  logic       fl2_stall, fl2_mux, fl2_fh;
  logic [7:0] fl2_pm;
`ifdef HDU_STALL_PERF_EN
  logic [31:0] def_sc, def_fc, fl2_sc, fl2_fc;
  logic [1:0]  ll3_sc, ll3_fc;
`endif

  int n_checks = 0;
  int n_errors = 0;

  hdu_scoreboard u_def (
    .clk(clk), .reset(reset), .dec_valid(v_def), .flush(flush),
    .dec_rs(rs), .dec_rd(rd), .dec_uses_rs(urs), .dec_uses_rd(urd),
    .dec_mem_to_reg(m2r), .dec_flags_read(fr), .dec_pop_flags(pf), .dec_pop_pc(ppc),
    .stall(def_stall), .mux_selector(def_mux), .fetch_hold(def_fh), .pending_mask(def_pm)
`ifdef HDU_STALL_PERF_EN
    , .stall_cycles(def_sc), .fetch_hold_cycles(def_fc)
`endif
  );

  hdu_scoreboard #(.LOAD_LAT(3), .CNT_W(2)) u_ll3 (
    .clk(clk), .reset(reset), .dec_valid(v_ll3), .flush(flush),
    .dec_rs(rs), .dec_rd(rd), .dec_uses_rs(urs), .dec_uses_rd(urd),
    .dec_mem_to_reg(m2r), .dec_flags_read(fr), .dec_pop_flags(pf), .dec_pop_pc(ppc),
    .stall(ll3_stall), .mux_selector(ll3_mux), .fetch_hold(ll3_fh), .pending_mask(ll3_pm)
`ifdef HDU_STALL_PERF_EN
    , .stall_cycles(ll3_sc), .fetch_hold_cycles(ll3_fc)
`endif
  );

  hdu_scoreboard #(.FLAGS_LAT(2), .PC_LAT(3)) u_fl2 (
    .clk(clk), .reset(reset), .dec_valid(v_fl2), .flush(flush),
    .dec_rs(rs), .dec_rd(rd), .dec_uses_rs(urs), .dec_uses_rd(urd),
    .dec_mem_to_reg(m2r), .dec_flags_read(fr), .dec_pop_flags(pf), .dec_pop_pc(ppc),
    .stall(fl2_stall), .mux_selector(fl2_mux), .fetch_hold(fl2_fh), .pending_mask(fl2_pm)
`ifdef HDU_STALL_PERF_EN
    , .stall_cycles(fl2_sc), .fetch_hold_cycles(fl2_fc)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // en bit0=u_def, bit1=u_ll3, bit2=u_fl2; inputs change on the falling edge, checks follow 1ns later.
  task automatic drv(input logic [2:0] en, input logic i_fl, input logic [2:0] i_rs, input logic [2:0] i_rd,
                     input logic i_urs, input logic i_urd, input logic i_m2r, input logic i_fr,
                     input logic i_pf, input logic i_ppc);
    @(negedge clk);
    v_def = en[0]; v_ll3 = en[1]; v_fl2 = en[2];
    flush = i_fl; rs = i_rs; rd = i_rd; urs = i_urs; urd = i_urd;
    m2r = i_m2r; fr = i_fr; pf = i_pf; ppc = i_ppc;
    #1;
  endtask

  initial begin
    reset = 1'b0;
    v_def = 1'b0; v_ll3 = 1'b0; v_fl2 = 1'b0;
    flush = 1'b0; urs = 1'b0; urd = 1'b0; m2r = 1'b0; fr = 1'b0; pf = 1'b0; ppc = 1'b0;
    rs = 3'd0; rd = 3'd0;

    // reset held: outputs quiet with every input asserted
    drv(3'b111, 1'b0, 3'd2, 3'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("rst_stall", {31'd0, def_stall}, 32'd0);
    chk("rst_mux",   {31'd0, def_mux},   32'd0);
    chk("rst_fh",    {31'd0, def_fh},    32'd0);
    chk("rst_pm",    {24'd0, def_pm},    32'd0);
    chk("rst_fl2_fh", {31'd0, fl2_fh},   32'd0);
    drv(3'b000, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // POP R2 then ADD R5,R2: one stall cycle
    drv(3'b001, 1'b0, 3'd0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("pop_r2_stall", {31'd0, def_stall}, 32'd0);
    chk("pop_r2_pm",    {24'd0, def_pm},    32'd0);
    drv(3'b001, 1'b0, 3'd2, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("add_dep_stall", {31'd0, def_stall}, 32'd1);
    chk("add_dep_mux",   {31'd0, def_mux},   32'd1);
    chk("add_dep_pm",    {24'd0, def_pm},    32'h04);
    drv(3'b001, 1'b0, 3'd2, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("add_rel_stall", {31'd0, def_stall}, 32'd0);
    chk("add_rel_mux",   {31'd0, def_mux},   32'd0);
    chk("add_rel_pm",    {24'd0, def_pm},    32'd0);

    // POP R3 reading rs=R3: never stalls on itself, but a second one waits
    drv(3'b001, 1'b0, 3'd3, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("self_pop_stall", {31'd0, def_stall}, 32'd0);
    drv(3'b001, 1'b0, 3'd3, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("pop2_stall", {31'd0, def_stall}, 32'd1);
    chk("pop2_pm",    {24'd0, def_pm},    32'h08);
    drv(3'b001, 1'b0, 3'd3, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("pop2_issue_stall", {31'd0, def_stall}, 32'd0);
    drv(3'b000, 1'b0, 3'd3, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("novalid_stall", {31'd0, def_stall}, 32'd0);
    chk("novalid_pm",    {24'd0, def_pm},    32'h08);
    drv(3'b000, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle_pm", {24'd0, def_pm}, 32'd0);

    // flushed dependent: no stall, no scoreboard update, R4 still expires
    drv(3'b001, 1'b0, 3'd0, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ldd_r4_stall", {31'd0, def_stall}, 32'd0);
    drv(3'b001, 1'b1, 3'd4, 3'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("flush_stall", {31'd0, def_stall}, 32'd0);
    chk("flush_mux",   {31'd0, def_mux},   32'd0);
    chk("flush_pm",    {24'd0, def_pm},    32'h10);
    drv(3'b001, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("flush_after_pm", {24'd0, def_pm}, 32'd0);

    // LOAD_LAT=3: LDD R1 then STD R1 stalls three cycles
    drv(3'b010, 1'b0, 3'd0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ll3_ldd_stall", {31'd0, ll3_stall}, 32'd0);
    drv(3'b010, 1'b0, 3'd0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ll3_std_c1", {31'd0, ll3_stall}, 32'd1);
    chk("ll3_std_pm", {24'd0, ll3_pm},    32'h02);
    drv(3'b010, 1'b0, 3'd0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ll3_std_c2", {31'd0, ll3_stall}, 32'd1);
    drv(3'b010, 1'b0, 3'd0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ll3_std_c3", {31'd0, ll3_stall}, 32'd1);
    chk("ll3_std_c3_mux", {31'd0, ll3_mux}, 32'd1);
    drv(3'b010, 1'b0, 3'd0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ll3_std_c4", {31'd0, ll3_stall}, 32'd0);
    chk("ll3_std_c4_pm", {24'd0, ll3_pm}, 32'd0);
`ifdef HDU_STALL_PERF_EN
    chk("ll3_stall_cycles", {30'd0, ll3_sc}, 32'd3);
`endif
    drv(3'b010, 1'b0, 3'd0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drv(3'b010, 1'b0, 3'd0, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ll3_indep_stall", {31'd0, ll3_stall}, 32'd0);
    chk("ll3_indep_pm",    {24'd0, ll3_pm},    32'h02);
    drv(3'b010, 1'b0, 3'd0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ll3_late_c1", {31'd0, ll3_stall}, 32'd1);
    drv(3'b010, 1'b0, 3'd0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ll3_late_c2", {31'd0, ll3_stall}, 32'd1);
`ifdef HDU_STALL_PERF_EN
    chk("ll3_stall_wrap", {30'd0, ll3_sc}, 32'd0);
`endif
    drv(3'b010, 1'b0, 3'd0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ll3_late_rel", {31'd0, ll3_stall}, 32'd0);

    // RTI with FLAGS_LAT=2, PC_LAT=3, then JZ
    drv(3'b100, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("rti_fh",    {31'd0, fl2_fh},    32'd1);
    chk("rti_stall", {31'd0, fl2_stall}, 32'd0);
    drv(3'b100, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("jz_c1_stall", {31'd0, fl2_stall}, 32'd1);
    chk("jz_c1_fh",    {31'd0, fl2_fh},    32'd1);
    drv(3'b100, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("jz_c2_stall", {31'd0, fl2_stall}, 32'd1);
    chk("jz_c2_fh",    {31'd0, fl2_fh},    32'd1);
    drv(3'b100, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("jz_c3_stall", {31'd0, fl2_stall}, 32'd0);
    chk("jz_c3_fh",    {31'd0, fl2_fh},    32'd1);
    drv(3'b100, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rti_done_fh", {31'd0, fl2_fh}, 32'd0);
`ifdef HDU_STALL_PERF_EN
    chk("fl2_fh_cycles",    fl2_fc, 32'd4);
    chk("fl2_stall_cycles", fl2_sc, 32'd2);
`endif
    drv(3'b100, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("flush_rti_fh", {31'd0, fl2_fh}, 32'd0);
    drv(3'b100, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("flush_rti_jz_stall", {31'd0, fl2_stall}, 32'd0);
    chk("flush_rti_jz_fh",    {31'd0, fl2_fh},    32'd0);

    // reset mid-operation with reg_cnt[6]=2 and pc_cnt=2
    drv(3'b010, 1'b0, 3'd0, 3'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("mid_issue_fh", {31'd0, ll3_fh}, 32'd1);
    drv(3'b000, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mid_c1_pm", {24'd0, ll3_pm}, 32'h40);
    drv(3'b000, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mid_c2_pm", {24'd0, ll3_pm}, 32'h40);
    chk("mid_c2_fh", {31'd0, ll3_fh}, 32'd1);
    reset = 1'b0;
    v_ll3 = 1'b1; urs = 1'b1; rs = 3'd6;
    #1;
    chk("mid_rst_pm",    {24'd0, ll3_pm},    32'd0);
    chk("mid_rst_fh",    {31'd0, ll3_fh},    32'd0);
    chk("mid_rst_stall", {31'd0, ll3_stall}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("post_rst_stall", {31'd0, ll3_stall}, 32'd0);
    chk("post_rst_pm",    {24'd0, ll3_pm},    32'd0);
    chk("post_rst_fh",    {31'd0, ll3_fh},    32'd0);
`ifdef HDU_STALL_PERF_EN
    chk("post_rst_sc", {30'd0, ll3_sc}, 32'd0);
`endif
    drv(3'b010, 1'b0, 3'd6, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_dep_stall", {31'd0, ll3_stall}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hdu_scoreboard.md
Name: hdu_scoreboard

Overview:
- Parametrised successor to the decode-stage hazard detection unit.
- Replaces the single-stage ALU-vs-decode compare with a per-register countdown scoreboard, so load/POP results with multi-cycle memory latency stall dependents for exactly the right number of cycles.
- Adds flags-pop tracking and a PC-pop (RET/RTI) fetch hold.
- Sits in decode; drives the decode hold and the bubble-insert mux select.

Parameters:
- REG_ADDR_W, 3, register address width; NUM_REGS = 2**REG_ADDR_W.
- LOAD_LAT, 1, cycles a memory-sourced register result is unavailable to decode after issue (>=1).
- FLAGS_LAT, 1, cycles popped flags are unavailable after issue (>=1).
- PC_LAT, 3, cycles fetch is held after a PC pop issues (>=1).
- CNT_W, 32, width of the stall performance counter (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- dec_valid  in  1  decode holds a valid instruction.
- flush  in  1  decode instruction is killed this cycle.
- dec_rs  in  REG_ADDR_W  source register.
- dec_rd  in  REG_ADDR_W  destination (also second source).
- dec_uses_rs  in  1  instruction reads rs.
- dec_uses_rd  in  1  instruction reads rd as a source (STD, OUT, JMP, ALU two-operand).
- dec_mem_to_reg  in  1  instruction writes rd from memory (LDD, POP).
- dec_flags_read  in  1  instruction consumes flags (conditional jump).
- dec_pop_flags  in  1  instruction restores flags from stack (RTI).
- dec_pop_pc  in  1  instruction restores PC from stack (RET, RTI).
- stall  out  1  hold fetch/decode registers this cycle.
- mux_selector  out  1  insert bubble (zero control) into decode/ALU register; equals stall.
- fetch_hold  out  1  freeze PC (PC-pop in flight).
- pending_mask  out  NUM_REGS  bit i set while reg_cnt[i] != 0.

Behaviour:
- State: reg_cnt[NUM_REGS], flags_cnt, pc_cnt. Each is a saturating-free down-counter wide enough for its latency.
- Reset (reset=0, async): all counters cleared. stall, mux_selector, fetch_hold and pending_mask are 0 with any inputs while the counters are zero.
- Hazard (combinational, same cycle):
  - hit_rs = dec_uses_rs & reg_cnt[dec_rs]!=0
  - hit_rd = dec_uses_rd & reg_cnt[dec_rd]!=0
  - hit_f = dec_flags_read & flags_cnt!=0
- stall = dec_valid & !flush & (hit_rs | hit_rd | hit_f).
- issue = dec_valid & !flush & !stall.
- Per clock, each nonzero counter decrements by 1.
- On issue:
  - dec_mem_to_reg sets reg_cnt[dec_rd] = LOAD_LAT.
  - dec_pop_flags sets flags_cnt = FLAGS_LAT.
  - dec_pop_pc sets pc_cnt = PC_LAT.
  - Set overrides decrement for the same entry in the same cycle.
- Hazard checks use pre-issue state, so an instruction never stalls on itself (e.g. POP R3 with rs=R3).
- LOAD_LAT=1: exactly one stall cycle for an immediately dependent instruction, matching previous load-use behaviour. The next instruction sees the count at LOAD_LAT and stalls LOAD_LAT cycles.
- fetch_hold = (pc_cnt != 0) | (issue & dec_pop_pc).
- While fetch_hold is high, decode inputs are bubbles from upstream. The block takes no special action for them.
- flush suppresses stall and issue for that cycle; pending counters keep counting (older instructions still complete).
- Reset mid-operation clears all pending state immediately; no stall after reset release.
- dec_valid=0: no stall, no issue; counters still decrement.

Optional Feature:
- Macro: HDU_STALL_PERF_EN.
- Enabled:
  - Extra output stall_cycles (CNT_W): counts cycles with stall=1.
  - Extra output fetch_hold_cycles (CNT_W): counts cycles with fetch_hold=1.
  - Both wrap modulo 2**CNT_W; reset to 0 asynchronously.
- Disabled: ports and counters absent; the remaining behaviour is identical.

Test Plan:
- Default parameters, POP R2 issues, next cycle ADD R5,R2 (uses_rs, rs=2) -> stall=1, mux_selector=1 for 1 cycle, then issue; pending_mask=8'h04 for 1 cycle.
- LOAD_LAT=3, LDD R1 then STD R1 (uses_rd, rd=1) -> stall high 3 consecutive cycles, releases on 4th; independent STD R4 in the same position -> no stall.
- RTI issues (pop_flags+pop_pc, PC_LAT=3) -> fetch_hold high in issue cycle plus 3 cycles; JZ next in decode with FLAGS_LAT=2 -> stall 2 cycles.
- Stalled dependent with flush=1 -> stall=0, no scoreboard update; pending counter still reaches 0 on schedule.
- reset pulsed low while reg_cnt[6]=2 and pc_cnt=2 -> immediately pending_mask=0, fetch_hold=0, stall=0; dependent on R6 after release -> no stall.
- HDU_STALL_PERF_EN defined, run scenario 2 -> stall_cycles=3; preload near 2**CNT_W-1 -> wraps to 0.
